// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite slave with a bank of REG_NUM byte-writable control registers.
// Optional macro AXI_LITE_REG_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi_lite_reg_slave #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [ADDR_W-1:0]         awaddr,
  input  logic [2:0]                awprot,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W/8-1:0]       wstrb,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [1:0]                bresp,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [ADDR_W-1:0]         araddr,
  input  logic [2:0]                arprot,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [DATA_W-1:0]         rdata,
  output logic [1:0]                rresp,
  output logic [REG_NUM*DATA_W-1:0] reg_q,
  output logic [REG_NUM-1:0]        wr_pulse
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_W - ADDR_LSB;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_LITE_REG_SLVERR_EN
  localparam logic [1:0] RESP_OOR = 2'b10;
`else
  localparam logic [1:0] RESP_OOR = 2'b00;
`endif

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e             wstate_q;
  rstate_e             rstate_q;
  logic [DATA_W-1:0]   regs_q [REG_NUM];
  logic                awready_q, wready_q, arready_q, bvalid_q, rvalid_q;
  logic                aw_held_q, w_held_q;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [1:0]          bresp_q, rresp_q;
  logic [REG_NUM-1:0]  wr_pulse_q;

  logic                aw_hs, w_hs, commit, wr_in_range, ar_in_range;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data, rd_val;
  logic [STRB_W-1:0]   wr_strb;
  logic [IDX_W-1:0]    wr_idx, ar_idx;

  // A channel accepted on an earlier cycle supplies its latched payload;
  // otherwise the live bus value is used so same-cycle AW+W commits at once.
  assign aw_hs       = awvalid & awready_q;
  assign w_hs        = wvalid & wready_q;
  assign wr_addr     = aw_held_q ? awaddr_q : awaddr;
  assign wr_data     = w_held_q ? wdata_q : wdata;
  assign wr_strb     = w_held_q ? wstrb_q : wstrb;
  assign wr_idx      = wr_addr[ADDR_W-1:ADDR_LSB];
  assign wr_in_range = int'(wr_idx) < REG_NUM;
  assign commit      = (wstate_q == W_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);

  assign ar_idx      = araddr[ADDR_W-1:ADDR_LSB];
  assign ar_in_range = int'(ar_idx) < REG_NUM;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (int'(ar_idx) == i) rd_val = regs_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q   <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_pulse_q <= '0;
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else begin
      wr_pulse_q <= '0;
      case (wstate_q)
        W_IDLE: begin
          if (commit) begin
            for (int i = 0; i < REG_NUM; i++) begin
              if (wr_in_range && int'(wr_idx) == i) begin
                wr_pulse_q[i] <= 1'b1;
                for (int b = 0; b < STRB_W; b++) begin
                  if (wr_strb[b]) regs_q[i][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
              end
            end
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_in_range ? RESP_OKAY : RESP_OOR;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            wstate_q  <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_held_q <= 1'b1;
              awaddr_q  <= awaddr;
              awready_q <= 1'b0;
            end else if (!aw_held_q) begin
              awready_q <= 1'b1;
            end
            if (w_hs) begin
              w_held_q <= 1'b1;
              wdata_q  <= wdata;
              wstrb_q  <= wstrb;
              wready_q <= 1'b0;
            end else if (!w_held_q) begin
              wready_q <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (arvalid && arready_q) begin
            rdata_q   <= rd_val;
            rresp_q   <= ar_in_range ? RESP_OKAY : RESP_OOR;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rstate_q  <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < REG_NUM; g++) begin : g_regout
    assign reg_q[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign awready  = awready_q;
  assign wready   = wready_q;
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign arready  = arready_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
  assign wr_pulse = wr_pulse_q;

  logic unused_bits;
  assign unused_bits = ^{awprot, arprot, wr_addr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Scoreboard bench for axi_lite_reg_slave: B/R responses are queued when issued and checked on handshake.
module tb_axi_lite_reg_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [7:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [255:0] reg_q;
  logic [7:0]  wr_pulse;

`ifdef AXI_LITE_REG_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  typedef struct packed { logic [31:0] data; logic [1:0] resp; } rexp_t;

  logic [1:0]  exp_b [$];
  rexp_t       exp_r [$];
  logic [31:0] mdl [8];
  int          n_chk = 0;
  int          n_fail = 0;

  axi_lite_reg_slave dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .reg_q(reg_q), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_reg%0d", tag, i), reg_q[i*32 +: 32], mdl[i]);
  endtask

  // Response monitor: pops the expected response when the handshake is visible.
  always @(negedge clk) begin
    if (!rst && bvalid && bready) begin
      if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
      else chk("bresp", bresp, exp_b.pop_front());
    end
    if (!rst && rvalid && rready) begin
      if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        rexp_t e;
        e = exp_r.pop_front();
        chk("rdata", rdata, e.data);
        chk("rresp", rresp, e.resp);
      end
    end
  end

  function automatic void model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a >> 2);
    if (idx < 8) begin
      for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
      exp_b.push_back(2'b00);
    end else begin
      exp_b.push_back(OOR);
    end
  endfunction

  function automatic rexp_t model_read(input logic [7:0] a);
    int idx;
    rexp_t e;
    idx = int'(a >> 2);
    if (idx < 8) begin e.data = mdl[idx]; e.resp = 2'b00; end
    else begin e.data = '0; e.resp = OOR; end
    return e;
  endfunction

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [7:0] ep;
    int k;
    ep = '0;
    k = 0;
    while (!(awready && wready) && k < 20) begin tick(); k++; end
    if (k == 20) chk("wr_ready_timeout", 0, 1);
    if ((a >> 2) < 8) ep[a >> 2] = 1'b1;
    awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s; bready = 1;
    model_write(a, d, s);
    tick();
    awvalid = 0; wvalid = 0;
    chk("wr_pulse", wr_pulse, ep);
    chk("wr_bvalid", bvalid, 1);
    chk_regs("wr");
    tick();
    bready = 0;
    chk("wr_bvalid_clr", bvalid, 0);
    chk("wr_pulse_clr", wr_pulse, 0);
  endtask

  task automatic rd(input logic [7:0] a, input int hold);
    rexp_t e;
    int k;
    k = 0;
    while (!arready && k < 20) begin tick(); k++; end
    if (k == 20) chk("rd_ready_timeout", 0, 1);
    e = model_read(a);
    exp_r.push_back(e);
    arvalid = 1; araddr = a; rready = 0;
    tick();
    arvalid = 0;
    chk("rd_rvalid", rvalid, 1);
    chk("rd_arready_low", arready, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("rd_hold_rvalid", rvalid, 1);
      chk("rd_hold_rdata", rdata, e.data);
      chk("rd_hold_arready", arready, 0);
    end
    rready = 1;
    tick();
    rready = 0;
    chk("rd_rvalid_clr", rvalid, 0);
    chk("rd_arready_back", arready, 1);
  endtask

  initial begin
    rst = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    tick(); tick();
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_wr_pulse", wr_pulse, 0);
    chk_regs("rst");
    rst = 0;
    tick();
    chk("rel_awready", awready, 1);
    chk("rel_wready", wready, 1);
    chk("rel_arready", arready, 1);

    // Same-cycle AW+W with a slow bready
    awvalid = 1; awaddr = 8'h04; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    model_write(8'h04, 32'hDEADBEEF, 4'hF);
    tick();
    awvalid = 0; wvalid = 0;
    chk("t1_reg1", reg_q[63:32], 32'hDEADBEEF);
    chk("t1_pulse", wr_pulse, 8'h02);
    chk("t1_bvalid", bvalid, 1);
    chk("t1_bresp", bresp, 0);
    chk("t1_awready", awready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_bvalid_hold", bvalid, 1);
      chk("t1_pulse_gone", wr_pulse, 0);
    end
    bready = 1;
    tick();
    bready = 0;
    chk("t1_bvalid_clr", bvalid, 0);
    chk("t1_awready_back", awready, 1);
    chk("t1_wready_back", wready, 1);

    // W before AW, partial strobe
    wr(8'h08, 32'h12345678, 4'hF);
    wvalid = 1; wdata = 32'h0000AB00; wstrb = 4'b0010; bready = 1;
    tick();
    wvalid = 0;
    chk("t2_wready_low", wready, 0);
    chk("t2_bvalid_wait", bvalid, 0);
    tick();
    chk("t2_bvalid_wait2", bvalid, 0);
    awvalid = 1; awaddr = 8'h08;
    model_write(8'h08, 32'h0000AB00, 4'b0010);
    tick();
    awvalid = 0;
    chk("t2_bvalid", bvalid, 1);
    chk("t2_reg2", reg_q[95:64], 32'h1234AB78);
    chk("t2_pulse", wr_pulse, 8'h04);
    tick();
    bready = 0;

    // Read with rready held low
    rd(8'h04, 4);

    // Same-cycle write and read of one register
    exp_r.push_back(model_read(8'h04));
    awvalid = 1; awaddr = 8'h04; wvalid = 1; wdata = 32'h11111111; wstrb = 4'hF; bready = 1;
    arvalid = 1; araddr = 8'h04;
    model_write(8'h04, 32'h11111111, 4'hF);
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("t5_reg1", reg_q[63:32], 32'h11111111);
    chk("t5_rdata", rdata, 32'hDEADBEEF);
    rready = 1;
    tick();
    rready = 0; bready = 0;
    chk("t5_rvalid_clr", rvalid, 0);

    // Boundaries: zero strobe, ignored low address bits, out-of-range index
    wr(8'h0C, 32'hFFFFFFFF, 4'h0);
    wr(8'h1F, 32'hA5A5A5A5, 4'hF);
    rd(8'h1D, 0);
    wr(8'h40, 32'hCAFEF00D, 4'hF);
    rd(8'h40, 1);
    rd(8'h08, 0);

    // Reset in the middle of a write aborts it and clears the bank
    wvalid = 1; wdata = 32'h55AA55AA; wstrb = 4'hF;
    tick();
    wvalid = 0;
    rst = 1;
    #1;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    chk("mr_wready", wready, 0);
    chk("mr_awready", awready, 0);
    chk_regs("mr");
    tick();
    rst = 0;
    tick();
    awvalid = 1; awaddr = 8'h00;
    tick();
    awvalid = 0;
    chk("mr_no_commit", bvalid, 0);
    chk("mr_reg0", reg_q[31:0], 0);
    wvalid = 1; wdata = 32'h00C0FFEE; wstrb = 4'hF; bready = 1;
    model_write(8'h00, 32'h00C0FFEE, 4'hF);
    tick();
    wvalid = 0;
    chk("mr_bvalid", bvalid, 1);
    chk("mr_reg0_new", reg_q[31:0], 32'h00C0FFEE);
    tick();
    bready = 0;

    tick(); tick();
    chk("sb_b_empty", exp_b.size(), 0);
    chk("sb_r_empty", exp_r.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
